// File: rtl/big_fb_writer.sv
// big_fb_writer
//   Host-side command port for the BIG framebuffer (2048 x 6-bit RRGGBB).
//   WRITE, READ and FILL commands are queued in a small FIFO. They touch the
//   framebuffer only while the VGA block reports blanking (en=1), so scan-out
//   never sees a half-updated frame. Commands execute strictly in order.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-low (0 = reset)
//   cmd_valid   host command strobe; accepted when cmd_ready is also 1
//   cmd_ready   queue can accept a command
//   cmd_op      00=WRITE, 01=READ, 10=FILL, 11=reserved (accepted, dropped)
//   cmd_addr    target address for WRITE/READ
//   cmd_data    pixel value for WRITE/FILL
//   rsp_valid   one-cycle pulse, rsp_data holds a READ result
//   rsp_data    last READ result, held until the next rsp_valid
//   busy        queue non-empty or a command executing
//   en          1 = display idle, framebuffer access allowed
//   fb_wr_en    framebuffer write enable
//   fb_wr_addr  framebuffer write address
//   fb_wr_data  framebuffer write data
//   fb_rd_addr  framebuffer read address
//   fb_rd_data  framebuffer read data, one-cycle synchronous latency
module big_fb_writer #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 6,
   parameter int FB_WORDS   = 2048,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   input  logic              en,
   output logic              fb_wr_en,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [DATA_W-1:0] fb_wr_data,
   output logic [ADDR_W-1:0] fb_rd_addr,
   input  logic [DATA_W-1:0] fb_rd_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   FILL_LAST = (ADDR_W+1)'(FB_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_ADDR,
      S_RD_DATA,
      S_FILL
   } state_t;

   // Command queue storage (no reset needed; occupancy is tracked by count)
   logic [1:0]        fifo_op   [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

   state_t            state_q,      state_d;
   logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
   logic [CNT_W-1:0]  count_q,      count_d;
   logic              cmd_ready_q,  cmd_ready_d;
   logic [ADDR_W-1:0] op_addr_q,    op_addr_d;
   logic [DATA_W-1:0] op_data_q,    op_data_d;
   // One bit wider than the address so the last word is reached without wrap
   logic [ADDR_W:0]   fill_cnt_q,   fill_cnt_d;
   logic              rd_armed_q,   rd_armed_d;
   logic              rsp_valid_q,  rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
   logic              fb_wr_en_q,   fb_wr_en_d;
   logic [ADDR_W-1:0] fb_wr_addr_q, fb_wr_addr_d;
   logic [DATA_W-1:0] fb_wr_data_q, fb_wr_data_d;
   logic [ADDR_W-1:0] fb_rd_addr_q, fb_rd_addr_d;

   logic push;
   logic pop;

   assign push = cmd_valid & cmd_ready_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr_q]   <= cmd_op;
         fifo_addr[wr_ptr_q] <= cmd_addr;
         fifo_data[wr_ptr_q] <= cmd_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_addr_d    = op_addr_q;
      op_data_d    = op_data_q;
      fill_cnt_d   = fill_cnt_q;
      rd_armed_d   = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = rsp_data_q;
      fb_wr_en_d   = 1'b0;
      fb_wr_addr_d = fb_wr_addr_q;
      fb_wr_data_d = fb_wr_data_q;
      fb_rd_addr_d = fb_rd_addr_q;
      pop          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop       = 1'b1;
               op_addr_d = fifo_addr[rd_ptr_q];
               op_data_d = fifo_data[rd_ptr_q];
               case (fifo_op[rd_ptr_q])
                  2'b00:   state_d = S_WR;
                  2'b01:   state_d = S_RD_ADDR;
                  2'b10: begin
                     state_d    = S_FILL;
                     fill_cnt_d = '0;
                  end
                  default: state_d = S_IDLE;   // reserved op: consumed, no effect
               endcase
            end
         end

         S_WR: begin
            if (en) begin
               fb_wr_en_d   = 1'b1;
               fb_wr_addr_d = op_addr_q;
               fb_wr_data_d = op_data_q;
               state_d      = S_IDLE;
            end
         end

         S_RD_ADDR: begin
            // The address register must already hold the target before an
            // edge with en=1 counts as the framebuffer read; rd_armed marks that.
            fb_rd_addr_d = op_addr_q;
            rd_armed_d   = 1'b1;
            if (en && rd_armed_q) begin
               state_d = S_RD_DATA;
            end
         end

         S_RD_DATA: begin
            // Address was sampled while en=1, so the data is good even if en dropped.
            rsp_data_d  = fb_rd_data;
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
         end

         S_FILL: begin
            if (en) begin
               fb_wr_en_d   = 1'b1;
               fb_wr_addr_d = fill_cnt_q[ADDR_W-1:0];
               fb_wr_data_d = op_data_q;
               fill_cnt_d   = fill_cnt_q + 1'b1;
               if (fill_cnt_q == FILL_LAST) begin
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      cmd_ready_d = (count_d != FIFO_FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cmd_ready_q  <= 1'b0;
         op_addr_q    <= '0;
         op_data_q    <= '0;
         fill_cnt_q   <= '0;
         rd_armed_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         fb_wr_en_q   <= 1'b0;
         fb_wr_addr_q <= '0;
         fb_wr_data_q <= '0;
         fb_rd_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cmd_ready_q  <= cmd_ready_d;
         op_addr_q    <= op_addr_d;
         op_data_q    <= op_data_d;
         fill_cnt_q   <= fill_cnt_d;
         rd_armed_q   <= rd_armed_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         fb_wr_en_q   <= fb_wr_en_d;
         fb_wr_addr_q <= fb_wr_addr_d;
         fb_wr_data_q <= fb_wr_data_d;
         fb_rd_addr_q <= fb_rd_addr_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = (count_q != '0) | (state_q != S_IDLE);
   assign fb_wr_en   = fb_wr_en_q;
   assign fb_wr_addr = fb_wr_addr_q;
   assign fb_wr_data = fb_wr_data_q;
   assign fb_rd_addr = fb_rd_addr_q;

endmodule

// File: tb/tb_big_fb_writer.sv
// Testbench for big_fb_writer: framebuffer BRAM model, reference model of the
// command semantics, scoreboard queues and a monitor comparing DUT outputs.
module tb_big_fb_writer;

   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 6;
   localparam int FB_WORDS   = 2048;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_data = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;
   logic              en = 1'b0;
   logic              fb_wr_en;
   logic [ADDR_W-1:0] fb_wr_addr;
   logic [DATA_W-1:0] fb_wr_data;
   logic [ADDR_W-1:0] fb_rd_addr;
   logic [DATA_W-1:0] fb_rd_data;

   always #5 clk = ~clk;

   big_fb_writer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .en(en),
      .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
      .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data)
   );

   // Framebuffer: one write port, one synchronous read port
   logic              mem_init = 1'b1;
   logic [DATA_W-1:0] fb_mem [FB_WORDS];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < FB_WORDS; i++) fb_mem[i] <= '0;
      end else if (fb_wr_en) begin
         fb_mem[fb_wr_addr] <= fb_wr_data;
      end
      fb_rd_data <= fb_mem[fb_rd_addr];
   end

   // Reference model state and scoreboard queues
   logic [DATA_W-1:0]        ref_mem  [FB_WORDS];
   logic [DATA_W-1:0]        snap_mem [FB_WORDS];
   logic [ADDR_W+DATA_W-1:0] wr_q [$];
   logic [DATA_W-1:0]        rd_q [$];

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   int rsp_seen = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected effects of one accepted command, in program order
   task automatic model_issue(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
      case (op)
         2'b00: begin
            ref_mem[a] = d;
            wr_q.push_back({a, d});
         end
         2'b01: rd_q.push_back(ref_mem[a]);
         2'b10: begin
            for (int i = 0; i < FB_WORDS; i++) begin
               ref_mem[i] = d;
               wr_q.push_back({ADDR_W'(i), d});
            end
         end
         default: ;
      endcase
   endtask

   // Monitor: en as seen by the DUT at each edge, outputs checked on negedge
   logic en_s = 1'b0;
   logic [ADDR_W+DATA_W-1:0] exp_wr;
   logic [DATA_W-1:0]        exp_rd;
   always @(posedge clk) en_s <= en;

   always @(negedge clk) begin
      if (fb_wr_en) begin
         wr_seen++;
         check(en_s, "wr_outside_blank", fb_wr_addr, 0);
         if (wr_q.size() == 0) begin
            check(1'b0, "wr_unexpected", {fb_wr_addr, fb_wr_data}, 0);
         end else begin
            exp_wr = wr_q.pop_front();
            check({fb_wr_addr, fb_wr_data} == exp_wr, "wr_addr_data",
                  {fb_wr_addr, fb_wr_data}, exp_wr);
         end
      end
      if (rsp_valid) begin
         rsp_seen++;
         if (rd_q.size() == 0) begin
            check(1'b0, "rsp_unexpected", rsp_data, 0);
         end else begin
            exp_rd = rd_q.pop_front();
            check(rsp_data == exp_rd, "rsp_data", rsp_data, exp_rd);
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
      bit done = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      for (int i = 0; i < 20000 && !done; i++) begin
         if (cmd_ready) begin
            model_issue(op, a, d);
            @(posedge clk);
            #1;
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      cmd_valid = 1'b0;
      if (!done) check(1'b0, "send_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         #1;
         if (!busy && !rsp_valid && wr_q.size() == 0 && rd_q.size() == 0) done = 1'b1;
      end
      check(done, "drain", wr_q.size() + rd_q.size(), 0);
   endtask

   bit rand_on;
   bit tog_on;
   int w0, r0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < FB_WORDS; i++) ref_mem[i] = '0;

      // 1: reset state
      repeat (3) @(negedge clk);
      check({cmd_ready, rsp_valid, rsp_data, busy, fb_wr_en, fb_wr_addr, fb_wr_data, fb_rd_addr} == '0,
            "reset_outputs",
            {cmd_ready, rsp_valid, rsp_data, busy, fb_wr_en, fb_wr_addr, fb_wr_data, fb_rd_addr}, 0);
      mem_init = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check(cmd_ready == 1'b1, "ready_after_reset", cmd_ready, 1);
      check(busy == 1'b0, "busy_after_reset", busy, 0);

      // 2: single write
      en = 1'b1;
      w0 = wr_seen;
      send(2'b00, 11'h123, 6'h2A);
      wait_idle(50);
      check(wr_seen == w0 + 1, "write_pulse_count", wr_seen - w0, 1);
      check(busy == 1'b0, "busy_after_write", busy, 0);

      // 3: read after write, en=1 then en=0
      r0 = rsp_seen;
      send(2'b00, 11'h010, 6'h15);
      send(2'b01, 11'h010, 6'h00);
      wait_idle(50);
      check(rsp_seen == r0 + 1, "raw_rsp_count", rsp_seen - r0, 1);
      check(rsp_data == 6'h15, "raw_rsp_data", rsp_data, 6'h15);
      en = 1'b0;
      w0 = wr_seen;
      r0 = rsp_seen;
      send(2'b00, 11'h020, 6'h2B);
      send(2'b01, 11'h020, 6'h00);
      repeat (20) @(negedge clk);
      check(wr_seen == w0 && rsp_seen == r0, "blocked_while_active",
            (wr_seen - w0) + (rsp_seen - r0), 0);
      check(busy == 1'b1, "busy_while_blocked", busy, 1);
      en = 1'b1;
      wait_idle(50);
      check(rsp_data == 6'h2B, "raw_rsp_data_late", rsp_data, 6'h2B);

      // 4: queue full with en=0 (one command executing plus FIFO_DEPTH queued)
      en = 1'b0;
      r0 = rsp_seen;
      send(2'b00, 11'h040, 6'h01);
      send(2'b00, 11'h041, 6'h02);
      send(2'b01, 11'h040, 6'h00);
      send(2'b00, 11'h040, 6'h03);
      send(2'b01, 11'h040, 6'h00);
      @(negedge clk);
      check(cmd_ready == 1'b0, "ready_low_when_full", cmd_ready, 0);
      fork
         send(2'b01, 11'h041, 6'h00);
         begin
            repeat (5) @(negedge clk);
            en = 1'b1;
         end
      join
      wait_idle(100);
      check(rsp_seen == r0 + 3, "full_rsp_count", rsp_seen - r0, 3);

      // Random mix of WRITE / READ / reserved under random blanking
      rand_on = 1'b1;
      fork
         while (rand_on) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) < 6);
         end
         begin
            for (int n = 0; n < 80; n++) begin
               int r;
               logic [1:0]        op;
               logic [ADDR_W-1:0] a;
               r  = $urandom_range(0, 9);
               op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : 2'b11;
               a  = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
               send(op, a, DATA_W'($urandom));
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            rand_on = 1'b0;
         end
      join
      en = 1'b1;
      wait_idle(2000);

      // 5: FILL with en toggling 16 on / 16 off
      w0 = wr_seen;
      tog_on = 1'b1;
      fork
         begin
            int k = 0;
            while (tog_on) begin
               @(negedge clk);
               en = ((k / 16) % 2 == 0);
               k++;
            end
         end
         begin
            send(2'b10, 11'h000, 6'h3F);
            wait_idle(6000);
            tog_on = 1'b0;
         end
      join
      check(wr_seen == w0 + FB_WORDS, "fill_write_count", wr_seen - w0, FB_WORDS);

      // 6: reset in the middle of a FILL
      en = 1'b1;
      for (int i = 0; i < FB_WORDS; i++) snap_mem[i] = ref_mem[i];
      send(2'b10, 11'h000, 6'h0A);
      begin
         bit found = 1'b0;
         for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            #1;
            if (fb_wr_en && fb_wr_addr == 11'd100) found = 1'b1;
         end
         check(found, "fill_reached_100", 0, 1);
      end
      rst = 1'b0;
      wr_q.delete();
      for (int i = 101; i < FB_WORDS; i++) ref_mem[i] = snap_mem[i];
      @(negedge clk);
      check(fb_wr_en == 1'b0, "fill_stops_on_reset", fb_wr_en, 0);
      repeat (3) @(negedge clk);
      check(busy == 1'b0 && cmd_ready == 1'b0, "in_reset_idle", {busy, cmd_ready}, 0);
      rst = 1'b1;
      @(negedge clk);
      check(cmd_ready == 1'b1 && busy == 1'b0, "ready_after_abort", {cmd_ready, busy}, 2);
      send(2'b01, 11'd100, 6'h00);
      send(2'b01, 11'd101, 6'h00);
      wait_idle(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
